// File: rtl/core_pkg.sv
// core_pkg: shared core defaults and the enums used by fetch and decode
package core_pkg;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  typedef enum logic [2:0] {
    F_BOOT,
    F_REQ,
    F_WAIT,
    F_HOLD,
    F_DROP
  } fetch_state_e;
  typedef enum logic [2:0] {
    OP_ALU,
    OP_ALUI,
    OP_LOAD,
    OP_STORE,
    OP_JCOND,
    OP_JUMP,
    OP_JLL,
    OP_JLRL
  } op_type_e;
  typedef enum logic [1:0] {
    RES_ALU,
    RES_MEM,
    RES_PC4,
    RES_IMM
  } result_src_e;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding slot for a fetched {instr, pc} pair
module fetch_skid_buffer
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  logic            full_q, full_d;
  logic [XLEN-1:0] instr_q, instr_d, pc_q, pc_d;

  // flush wins, and a push beside a pop refills the entry in place
  always_comb begin
    full_d  = flush_i ? 1'b0 : push_i ? 1'b1 : pop_i ? 1'b0 : full_q;
    instr_d = push_i ? instr_i : instr_q;
    pc_d    = push_i ? pc_i : pc_q;
  end

  // entry register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, imem req/gnt/rvalid handshake and one output slot to decode
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets misalign_o and parks in HOLD
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pc_plus4_o,
  output logic            misalign_o
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic            misalign_q, misalign_d;
  logic            slot_free, resp;
  logic            skid_push, skid_pop, skid_full, skid_full_nxt;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic [XLEN-1:0] target;
  logic            bad_target;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = redirect_pc_i;
  assign bad_target = redirect_pc_i[1:0] != 2'b00;
`else
  assign target     = redirect_pc_i & ~XLEN'(3);
  assign bad_target = 1'b0;
`endif

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (skid_push),
    .pop_i  (skid_pop),
    .flush_i(redirect_i),
    .instr_i(imem_rdata_i),
    .pc_i   (req_pc_q),
    .full_o (skid_full),
    .instr_o(skid_instr),
    .pc_o   (skid_pc)
  );

  // output slot and skid steering; the skid drains before any new response
  always_comb begin
    slot_free     = !out_valid_q || !stall_i;
    resp          = state_q == F_WAIT && imem_rvalid_i && !redirect_i;
    skid_pop      = slot_free && skid_full && !redirect_i;
    skid_push     = resp && (!slot_free || skid_full);
    skid_full_nxt = !redirect_i && (skid_push || (skid_full && !skid_pop));
    out_valid_d   = !redirect_i && (skid_pop || (resp && slot_free) || (out_valid_q && stall_i));
    out_instr_d   = skid_pop ? skid_instr : (resp && slot_free) ? imem_rdata_i : out_instr_q;
    out_pc_d      = skid_pop ? skid_pc : (resp && slot_free) ? req_pc_q : out_pc_q;
    misalign_d    = misalign_q || (redirect_i && bad_target);
  end

  // next state and PC; redirect beats everything, a trapped misalign pins HOLD
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_i) begin
      pc_d    = target;
      state_d = ((state_q == F_REQ && imem_gnt_i) || (state_q == F_WAIT && !imem_rvalid_i)) ? F_DROP : F_REQ;
      if (misalign_q || bad_target) state_d = F_HOLD;
    end else begin
      case (state_q)
        F_BOOT: if (!imem_rvalid_i) state_d = F_REQ;
        F_REQ: begin
          if (imem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + XLEN'(4);
            state_d  = F_WAIT;
          end
        end
        F_WAIT: if (imem_rvalid_i) state_d = skid_full_nxt ? F_HOLD : F_REQ;
        F_HOLD: if (!skid_full_nxt && !misalign_q) state_d = F_REQ;
        F_DROP: if (imem_rvalid_i) state_d = F_REQ;
        default: state_d = F_BOOT;
      endcase
    end
  end

  // state, PC and output slot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= F_BOOT;
      pc_q        <= RESET_VECTOR;
      req_pc_q    <= RESET_VECTOR;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= RESET_VECTOR;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_req_o    = state_q == F_REQ;
  assign imem_addr_o   = pc_q;
  assign if_valid_o    = out_valid_q;
  assign if_instr_o    = out_instr_q;
  assign if_pc_o       = out_pc_q;
  assign if_pc_plus4_o = out_pc_q + XLEN'(4);
  assign misalign_o    = misalign_q;
endmodule
